// File: rtl/softmax_seq_ctrl.sv
// Three-phase softmax sequencer: max-scan, exp/accumulate, normalize, with a host start/done handshake.
// Optional macro SOFTMAX_SEQ_CTRL_PERF_EN adds the o_cycle_cnt busy-cycle counter.
module softmax_seq_ctrl #(
  parameter int MAX_LEN  = 16,
  parameter int IDX_W    = $clog2(MAX_LEN),
  parameter int LEN_W    = IDX_W + 1,
  parameter int EXP_LAT  = 2,
  parameter int NORM_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [LEN_W-1:0] i_vec_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_len_err,
  output logic [1:0]       o_phase,
  output logic             o_rd_en,
  output logic [IDX_W-1:0] o_rd_addr,
  output logic             o_max_clr,
  output logic             o_max_en,
  output logic             o_acc_clr,
  output logic             o_acc_en,
  output logic             o_norm_en,
  output logic             o_out_valid,
  output logic [IDX_W-1:0] o_out_idx,
  input  logic             i_out_ready
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]      o_cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAX_SCAN, S_MAX_FLUSH, S_EXP_ACC, S_EXP_FLUSH, S_NORM_RD, S_NORM_WAIT, S_DONE
  } state_t;

  localparam int CNT_MAX = (EXP_LAT > NORM_LAT) ? EXP_LAT : NORM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_addr;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [EXP_LAT:0]   r_acc_sr;
  logic               r_busy, r_done, r_len_err, r_rd_en;
  logic               r_max_clr, r_max_en, r_acc_clr, r_norm_en, r_out_valid;
  logic [1:0]         r_phase;
  logic [IDX_W-1:0]   r_out_idx;

  logic w_last, w_len_bad, w_accept;

  assign w_last    = (r_addr == r_last);
  assign w_len_bad = (i_vec_len == '0) || (i_vec_len > LEN_W'(MAX_LEN));
  assign w_accept  = (r_state == S_IDLE) && i_start && !w_len_bad;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_acc_sr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_len_err   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_max_clr   <= 1'b0;
      r_max_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_norm_en   <= 1'b0;
      r_out_valid <= 1'b0;
      r_phase     <= 2'd0;
      r_out_idx   <= '0;
    end else begin
      r_max_clr <= 1'b0;
      r_acc_clr <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_norm_en <= 1'b0;
      // Compare and accumulate strobes are delayed copies of the phase's buffer reads.
      r_max_en  <= r_rd_en && (r_phase == 2'd1);
      r_acc_sr  <= {r_acc_sr[EXP_LAT-1:0], r_rd_en && (r_phase == 2'd2)};

      if (i_abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_phase     <= 2'd0;
        r_rd_en     <= 1'b0;
        r_max_en    <= 1'b0;
        r_acc_sr    <= '0;
        r_out_valid <= 1'b0;
        r_acc_clr   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_len_bad) begin
                r_len_err <= 1'b1;
              end else begin
                r_state   <= S_MAX_SCAN;
                r_last    <= IDX_W'(i_vec_len - LEN_W'(1));
                r_addr    <= '0;
                r_rd_en   <= 1'b1;
                r_busy    <= 1'b1;
                r_phase   <= 2'd1;
                r_max_clr <= 1'b1;
                r_acc_clr <= 1'b1;
              end
            end
          end
          S_MAX_SCAN: begin
            if (w_last) begin
              r_state <= S_MAX_FLUSH;
              r_rd_en <= 1'b0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
          S_MAX_FLUSH: begin
            r_state <= S_EXP_ACC;
            r_addr  <= '0;
            r_rd_en <= 1'b1;
            r_phase <= 2'd2;
          end
          S_EXP_ACC: begin
            if (w_last) begin
              r_state <= S_EXP_FLUSH;
              r_rd_en <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
          S_EXP_FLUSH: begin
            if (r_cnt == CNT_W'(EXP_LAT)) begin
              r_state <= S_NORM_RD;
              r_addr  <= '0;
              r_rd_en <= 1'b1;
              r_phase <= 2'd3;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_NORM_RD: begin
            r_state   <= S_NORM_WAIT;
            r_rd_en   <= 1'b0;
            r_norm_en <= 1'b1;
            r_cnt     <= '0;
          end
          S_NORM_WAIT: begin
            // Divider latency is tracked by a counter; result stays frozen until accepted.
            if (!r_out_valid) begin
              if (r_cnt == CNT_W'(NORM_LAT - 1)) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= r_addr;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (i_out_ready) begin
              r_out_valid <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_NORM_RD;
                r_addr  <= r_addr + 1'b1;
                r_rd_en <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_phase <= 2'd0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept) begin
      r_cycle_cnt <= '0;
    end else if (r_busy && (r_cycle_cnt != '1)) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_len_err   = r_len_err;
  assign o_phase     = r_phase;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_addr;
  assign o_max_clr   = r_max_clr;
  assign o_max_en    = r_max_en;
  assign o_acc_clr   = r_acc_clr;
  assign o_acc_en    = r_acc_sr[EXP_LAT];
  assign o_norm_en   = r_norm_en;
  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl: directed passes with hand-computed cycle timing.
module tb_softmax_seq_ctrl;
  localparam int MAX_LEN  = 16;
  localparam int IDX_W    = 4;
  localparam int LEN_W    = 5;
  localparam int DONE_TOK = 100;

  logic             clk = 1'b0;
  logic             rst, start, abort, out_ready;
  logic [LEN_W-1:0] vec_len;
  logic             busy, done, len_err, rd_en, max_clr, max_en, acc_clr, acc_en, norm_en, out_valid;
  logic [1:0]       phase;
  logic [IDX_W-1:0] rd_addr, out_idx;
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
  logic [31:0]      cycle_cnt;
`endif

  always #5 clk = ~clk;

  softmax_seq_ctrl #(.MAX_LEN(MAX_LEN), .EXP_LAT(2), .NORM_LAT(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_vec_len(vec_len),
    .o_busy(busy), .o_done(done), .o_len_err(len_err), .o_phase(phase),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_max_clr(max_clr), .o_max_en(max_en),
    .o_acc_clr(acc_clr), .o_acc_en(acc_en), .o_norm_en(norm_en),
    .o_out_valid(out_valid), .o_out_idx(out_idx), .i_out_ready(out_ready)
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
    , .o_cycle_cnt(cycle_cnt)
`endif
  );

  logic [19:0] all_out;
  assign all_out = {busy, done, len_err, phase, rd_en, rd_addr, max_clr, max_en,
                    acc_clr, acc_en, norm_en, out_valid, out_idx};

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every result handshake or done pulse pops the next expected event.
  always @(negedge clk) begin
    int evt;
    int tok;
    if (!rst && ((out_valid && out_ready) || done)) begin
      evt = done ? DONE_TOK : int'(out_idx);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got event %0d, expected none", evt);
      end else begin
        tok = exp_q.pop_front();
        check("sb_event", evt, tok);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push_pass(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(i);
    exp_q.push_back(DONE_TOK);
  endtask

  task automatic launch(input int len);
    start   = 1'b1;
    vec_len = LEN_W'(len);
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done) break;
      step();
    end
    check(name, done, 1);
    step();
  endtask

  logic [63:0] lg_rd, lg_max, lg_acc, lg_norm, lg_val, lg_done, lg_busy, lg_mclr, lg_aclr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    logic seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; vec_len = '0; out_ready = 1'b1;
    repeat (3) step();
    check("reset_outputs", all_out, 0);
    rst = 1'b0;
    step();

    // L=4 reference timing, start sampled at end of c0
    push_pass(4);
    lg_rd = '0; lg_max = '0; lg_acc = '0; lg_norm = '0; lg_val = '0;
    lg_done = '0; lg_busy = '0; lg_mclr = '0; lg_aclr = '0;
    launch(4);
    for (int k = 1; k <= 40; k++) begin
      lg_rd[k] = rd_en;  lg_max[k] = max_en;   lg_acc[k] = acc_en;  lg_norm[k] = norm_en;
      lg_val[k] = out_valid; lg_done[k] = done; lg_busy[k] = busy;
      lg_mclr[k] = max_clr;  lg_aclr[k] = acc_clr;
      step();
    end
    check("l4_rd_en",  lg_rd,  rng(1,4) | rng(6,9) | rng(13,13) | rng(18,18) | rng(23,23) | rng(28,28));
    check("l4_max_en", lg_max, rng(2,5));
    check("l4_acc_en", lg_acc, rng(9,12));
    check("l4_norm_en", lg_norm, rng(14,14) | rng(19,19) | rng(24,24) | rng(29,29));
    check("l4_out_valid", lg_val, rng(17,17) | rng(22,22) | rng(27,27) | rng(32,32));
    check("l4_done", lg_done, rng(33,33));
    check("l4_busy", lg_busy, rng(1,33));
    check("l4_max_clr", lg_mclr, rng(1,1));
    check("l4_acc_clr", lg_aclr, rng(1,1));
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
    check("perf_cnt_end", cycle_cnt, 33);
    repeat (3) step();
    check("perf_cnt_hold", cycle_cnt, 33);
`endif

    // synchronous reset in the middle of MAX_SCAN
    launch(4);
    step();
    rst = 1'b1;
    step();
    check("mid_reset_outputs", all_out, 0);
    rst = 1'b0;
    step();
    check("mid_reset_idle", busy, 0);

    // backpressure on result 2
    push_pass(4);
    launch(4);
    found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid && out_idx == 4'd2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("stall_reach_idx2", found, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_idx", out_idx, 2);
      check("stall_no_rd", rd_en, 0);
    end
    out_ready = 1'b1;
    wait_done("stall_done", 80);

    // illegal lengths
    for (int j = 0; j < 2; j++) begin
      launch(j == 0 ? 0 : 17);
      check("len_err_pulse", len_err, 1);
      check("len_err_busy", busy, 0);
      step();
      check("len_err_clear", len_err, 0);
      check("len_err_still_idle", busy, 0);
    end

    // abort at EXP_ACC k=2 (cycle c8)
    launch(4);
    repeat (7) step();
    check("abort_at_exp_k2", {phase, rd_en, rd_addr}, {2'd2, 1'b1, 4'd2});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {busy, rd_en, acc_clr}, 3'b001);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen = seen | acc_en | out_valid | done | max_en;
      step();
    end
    check("abort_drained", seen, 0);

    // start with abort in IDLE, L=1 boundary
    push_pass(1);
    abort = 1'b1;
    launch(1);
    abort = 1'b0;
    check("start_beats_abort", busy, 1);
    wait_done("l1_done", 40);

    repeat (3) step();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
